// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one sequential Booth multiplier between two requesters.
// Each accepted request goes through IDLE -> START -> WAIT -> RESP. A WAIT
// that lasts MAX_WAIT cycles without mul_done aborts the multiplier and
// returns an error response.
// Build option: define MULT_ARB_RR_EN for round-robin grant. Otherwise
// requester 0 has fixed priority.
module mult_arbiter #(
   parameter int MAX_WAIT = 48
) (
   input  logic        clk,
   input  logic        rst,          // asynchronous, active low
   input  logic        req0_valid,
   input  logic [31:0] req0_m,
   input  logic [31:0] req0_q,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_m,
   input  logic [31:0] req1_q,
   output logic        req1_ready,
   output logic        rsp_valid,
   output logic        rsp_id,
   output logic [63:0] rsp_result,
   output logic        rsp_err,
   input  logic        rsp_ready,
   output logic [31:0] mul_M,
   output logic [31:0] mul_Q,
   output logic        mul_start,
   output logic        mul_rst,
   input  logic        mul_done,
   input  logic [63:0] mul_result
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [31:0]        opa_q, opa_d;
   logic [31:0]        opb_q, opb_d;
   logic               id_q, id_d;
   logic [63:0]        result_q, result_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               mrst_q, mrst_d;
   logic               grant1;
   logic               grant_any;

`ifdef MULT_ARB_RR_EN
   // prio_q names the requester that wins when both are valid.
   logic               prio_q, prio_d;

   // Round-robin: on a tie the requester not granted last wins.
   always_comb begin
      grant1 = req1_valid && (!req0_valid || prio_q);
   end
`else
   // Fixed priority: requester 0 wins every tie.
   always_comb begin
      grant1 = req1_valid && !req0_valid;
   end
`endif

   assign grant_any  = req0_valid || req1_valid;

   // Ready is combinational and goes only to the requester that holds the grant, and only in IDLE.
   assign req0_ready = (state_q == S_IDLE) && req0_valid && !grant1;
   assign req1_ready = (state_q == S_IDLE) && grant1;

   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_id     = id_q;
   assign rsp_result = result_q;
   assign rsp_err    = err_q;
   assign mul_M      = opa_q;
   assign mul_Q      = opb_q;
   assign mul_start  = (state_q == S_START);
   // The multiplier is also held in reset whenever the arbiter is in reset.
   assign mul_rst    = !rst || mrst_q;

   // Next-state and datapath updates for the request/response sequence.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      id_d     = id_q;
      result_d = result_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      mrst_d   = 1'b0;
`ifdef MULT_ARB_RR_EN
      prio_d   = prio_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (grant_any) begin
               // The handshake happens in this cycle, so capture the winner's operands now.
               opa_d   = grant1 ? req1_m : req0_m;
               opb_d   = grant1 ? req1_q : req0_q;
               id_d    = grant1;
               state_d = S_START;
`ifdef MULT_ARB_RR_EN
               prio_d  = !grant1;
`endif
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // In the first WAIT cycle mul_done may still hold over from the previous product.
            if ((cnt_q != '0) && mul_done) begin
               result_d = mul_result;
               err_d    = 1'b0;
               state_d  = S_RESP;
            end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
               result_d = '0;
               err_d    = 1'b1;
               mrst_d   = 1'b1;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers. Reset returns everything to a clean IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
         state_q  <= S_IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         id_q     <= 1'b0;
         result_q <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         mrst_q   <= 1'b0;
`ifdef MULT_ARB_RR_EN
         prio_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         id_q     <= id_d;
         result_q <= result_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         mrst_q   <= mrst_d;
`ifdef MULT_ARB_RR_EN
         prio_q   <= prio_d;
`endif
      end
   end

endmodule
